dd_spi_frame_rx: RTL and testbench

Parametrised SPI frame receiver for the DigiDoggs pixel engine. It replaces the fixed single-stream SPI hookup with a block that:
- oversamples the breakout-board SPI pins in the system clock domain;
- assembles NUM_WORDS words of WORD_W bits each into one frame;
- holds the frame in an output buffer under a valid/ack handshake.

It sits between the wrapper's gpio_in pins and the Mandelbrot core's configuration inputs. It flags short, long, overrun and (optionally) parity-failed frames.

---
 rtl/dd_spi_pkg.sv | 23 ++
 rtl/dd_sync_edge.sv | 34 +++
 rtl/dd_spi_frame_rx.sv | 162 ++++++++++++++++
 tb/tb_dd_spi_frame_rx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dd_spi_pkg.sv
// Shared types and constants for the DigiDoggs SPI frame receiver.
// Optional feature macro: DD_SPI_PARITY_EN (trailing even-parity bit per frame).
package dd_spi_pkg;

  localparam int DEF_WORD_W    = 16;
  localparam int DEF_NUM_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Number of SPI bits that make up a well-formed frame.
  function automatic int exp_bits(input int frame_w);
`ifdef DD_SPI_PARITY_EN
    return frame_w + 1;
`else
    return frame_w;
`endif
  endfunction

endpackage

// File: rtl/dd_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus rising/falling
// edge detect on the synchronised level.
module dd_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the pin through the chain; keep last synced level for edge detect.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // No reset here on purpose: the chain keeps tracking the pin while the
  // rest of the block is held in reset, so the level seen on reset release
  // is the real pin level rather than a fake 0 that would look like an edge.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
    prev_q <= prev_d;
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/dd_spi_frame_rx.sv
// SPI frame receiver: oversamples spi_clk/spi_en/spi_data, assembles
// NUM_WORDS x WORD_W bits into one frame and holds it under valid/ack.
// Optional feature macro: DD_SPI_PARITY_EN (frame followed by an even-parity
// bit, checked and dropped).
module dd_spi_frame_rx
  import dd_spi_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int NUM_WORDS   = DEF_NUM_WORDS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        ncs,
  input  logic                        spi_clk,
  input  logic                        spi_en,
  input  logic                        spi_data,
  output logic [WORD_W*NUM_WORDS-1:0] frame_data,
  output logic                        frame_valid,
  input  logic                        frame_ack,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        busy
);

  localparam int FRAME_W  = WORD_W * NUM_WORDS;
  localparam int EXP_BITS = exp_bits(FRAME_W);
  localparam int CNT_MAX  = FRAME_W + 2;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXP_BITS);
  localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(CNT_MAX);

  logic clk_s, bit_stb, clk_fall_unused;
  logic en_s, en_rise_unused, en_fall_unused;
  logic dat_s, unused_dat_rise, unused_dat_fall;

  dd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk (clk), .d (spi_clk), .q (clk_s), .rise (bit_stb), .fall (clk_fall_unused)
  );

  dd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
    .clk (clk), .d (spi_en), .q (en_s), .rise (en_rise_unused), .fall (en_fall_unused)
  );

  // Data goes through an identical chain so it stays aligned with bit_stb.
  dd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
    .clk (clk), .d (spi_data), .q (dat_s), .rise (unused_dat_rise), .fall (unused_dat_fall)
  );

  logic unused_sync;
  assign unused_sync = clk_s ^ clk_fall_unused ^ en_rise_unused ^ en_fall_unused;

  state_e               state_q, state_d;
  logic [EXP_BITS-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 armed_q, armed_d;
  logic [FRAME_W-1:0]   data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 err_c;

  logic [FRAME_W-1:0]   frame_word;
  logic                 parity_ok;
  logic                 frame_good;

`ifdef DD_SPI_PARITY_EN
  // Parity bit lands in the LSB; XOR over frame + parity must be 0.
  assign frame_word = sr_q[EXP_BITS-1:1];
  assign parity_ok  = ~^sr_q;
`else
  assign frame_word = sr_q;
  assign parity_ok  = 1'b1;
`endif

  assign frame_good = (cnt_q == EXP_CNT) && parity_ok;

  // Next-state, shift/count, and output-buffer handshake.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    err_c   = 1'b0;

    // A frame may only start after spi_en has been seen low, so a frame
    // cut off by reset or ncs is never resumed half way through.
    if (!en_s) armed_d = 1'b1;

    if (frame_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!ncs && en_s && armed_q) begin
          state_d = SHIFT;
          sr_d    = '0;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end
      SHIFT: begin
        if (ncs) begin
          state_d = IDLE;
        end else begin
          if (bit_stb) begin
            if (cnt_q < EXP_CNT) sr_d  = {sr_q[EXP_BITS-2:0], dat_s};
            if (cnt_q < SAT_CNT) cnt_d = cnt_q + CNT_W'(1);
          end
          if (!en_s) state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!ncs) begin
          if (frame_good) begin
            data_d  = frame_word;
            valid_d = 1'b1;
            // Same-cycle ack hands over the old frame, so that is no overrun.
            if (valid_q && !frame_ack) ovr_d = 1'b1;
          end else begin
            err_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign overrun     = ovr_q;
  assign frame_err   = err_c;
  assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_dd_spi_frame_rx.sv
// Self-checking bench for dd_spi_frame_rx (WORD_W=16, NUM_WORDS=4).
// Honors DD_SPI_PARITY_EN when defined.
module tb_dd_spi_frame_rx;
  import dd_spi_pkg::*;

  localparam int WORD_W      = 16;
  localparam int NUM_WORDS   = 4;
  localparam int FRAME_W     = WORD_W * NUM_WORDS;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;
  localparam int EXP         = exp_bits(FRAME_W);

  logic               clk = 1'b0;
  logic               n_rst, ncs, spi_clk, spi_en, spi_data, frame_ack;
  logic [FRAME_W-1:0] frame_data;
  logic               frame_valid, frame_err, overrun, busy;

  dd_spi_frame_rx #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk (clk), .n_rst (n_rst), .ncs (ncs), .spi_clk (spi_clk), .spi_en (spi_en),
    .spi_data (spi_data), .frame_data (frame_data), .frame_valid (frame_valid),
    .frame_ack (frame_ack), .frame_err (frame_err), .overrun (overrun), .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]         errs;
    logic               valid;
    logic               ovr;
    logic [FRAME_W-1:0] data;
  } out_t;

  out_t               exp_q[$];
  out_t               obs, e;
  logic [1:0]         errs;
  logic [FRAME_W-1:0] m_data;
  logic               m_valid, m_ovr;
  int                 n_checks = 0;
  int                 n_fail   = 0;

  // ---------------- model / scoreboard producers ----------------
  task automatic model_good(input logic [FRAME_W-1:0] d);
    if (m_valid) m_ovr = 1'b1;
    m_data  = d;
    m_valid = 1'b1;
    exp_q.push_back({2'd0, m_valid, m_ovr, m_data});
  endtask

  task automatic model_bad();
    exp_q.push_back({2'd1, m_valid, m_ovr, m_data});
  endtask

  task automatic model_none();
    exp_q.push_back({2'd0, m_valid, m_ovr, m_data});
  endtask

  // ---------------- stimulus ----------------
  function automatic logic [127:0] good_vec(input logic [FRAME_W-1:0] d);
`ifdef DD_SPI_PARITY_EN
    return {63'd0, d, ^d};
`else
    return {64'd0, d};
`endif
  endfunction

  task automatic en_on();
    spi_en = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic clock_bits(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_data = v[i];
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_bits(input logic [127:0] v, input int n);
    en_on();
    clock_bits(v, n);
    spi_en = 1'b0;
  endtask

  task automatic send_good(input logic [FRAME_W-1:0] d);
    send_bits(good_vec(d), EXP);
  endtask

  // Fixed window after spi_en drops; counts frame_err cycles (saturating).
  task automatic wait_done(output logic [1:0] n_err);
    n_err = 2'd0;
    repeat (20) begin
      @(negedge clk);
      if (frame_err === 1'b1 && n_err != 2'd3) n_err = n_err + 2'd1;
    end
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_rst = 1'b0; ncs = 1'b0; spi_clk = 1'b0; spi_en = 1'b0; spi_data = 1'b0; frame_ack = 1'b0;
    m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({frame_valid, overrun, frame_err, busy, frame_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b o=%b e=%b b=%b d=%h expected all zero",
               frame_valid, overrun, frame_err, busy, frame_data);
    end
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_good_frame();
    model_good(64'h0123_4567_89AB_CDEF);
    send_good(64'h0123_4567_89AB_CDEF);
    wait_done(errs);
    obs = {errs, frame_valid, overrun, frame_data};
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL good_frame: got %h expected %h", obs, e); end
    do_ack();
    n_checks++;
    if ({frame_valid, overrun} !== {m_valid, m_ovr}) begin
      n_fail++; $display("FAIL ack_clear: got v=%b o=%b expected v=%b o=%b", frame_valid, overrun, m_valid, m_ovr);
    end
  endtask

  task automatic test_bad_length();
    int lens[3];
    lens = '{63, EXP + 1, EXP + 6};
    foreach (lens[k]) begin
      model_bad();
      send_bits({2{64'hFEDC_BA98_7654_3210}}, lens[k]);
      wait_done(errs);
      obs = {errs, frame_valid, overrun, frame_data};
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL bad_len_%0d: got %h expected %h", lens[k], obs, e); end
    end
  endtask

  task automatic test_back_to_back_overrun();
    logic [FRAME_W-1:0] pat[2];
    pat = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
    foreach (pat[k]) begin
      model_good(pat[k]);
      send_good(pat[k]);
      wait_done(errs);
      obs = {errs, frame_valid, overrun, frame_data};
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL overrun_frame%0d: got %h expected %h", k, obs, e); end
    end
    do_ack();
    n_checks++;
    if ({frame_valid, overrun} !== {m_valid, m_ovr}) begin
      n_fail++; $display("FAIL overrun_ack: got v=%b o=%b expected v=%b o=%b", frame_valid, overrun, m_valid, m_ovr);
    end
  endtask

  task automatic test_ncs_abort();
    en_on();
    clock_bits({2{64'h1357_9BDF_2468_ACE0}}, 30);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_shift: got %b expected 1", busy); end
    ncs = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ncs_idle: got busy=%b expected 0", busy); end
    model_none();
    spi_en = 1'b0;
    wait_done(errs);
    obs = {errs, frame_valid, overrun, frame_data};
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL ncs_discard: got %h expected %h", obs, e); end
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    model_good(64'hC0DE_CAFE_BEEF_F00D);
    send_good(64'hC0DE_CAFE_BEEF_F00D);
    wait_done(errs);
    obs = {errs, frame_valid, overrun, frame_data};
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL ncs_next_frame: got %h expected %h", obs, e); end
    do_ack();
  endtask

  task automatic test_reset_mid_frame();
    model_good(64'h0F0F_1E1E_2D2D_3C3C);
    send_good(64'h0F0F_1E1E_2D2D_3C3C);
    wait_done(errs);
    obs = {errs, frame_valid, overrun, frame_data};
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL prereset_frame: got %h expected %h", obs, e); end
    en_on();
    clock_bits({2{64'h0123_4567_89AB_CDEF}}, 40);
    n_rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({frame_valid, overrun, frame_err, busy, frame_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b o=%b e=%b b=%b d=%h expected all zero",
               frame_valid, overrun, frame_err, busy, frame_data);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
    clock_bits({2{64'hFFFF_0000_FFFF_0000}}, 8);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rearm_after_reset: got busy=%b expected 0", busy); end
    model_none();
    spi_en = 1'b0;
    wait_done(errs);
    obs = {errs, frame_valid, overrun, frame_data};
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_tail: got %h expected %h", obs, e); end
    model_good(64'h8000_0000_0000_0001);
    send_good(64'h8000_0000_0000_0001);
    wait_done(errs);
    obs = {errs, frame_valid, overrun, frame_data};
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL postreset_frame: got %h expected %h", obs, e); end
    do_ack();
  endtask

`ifdef DD_SPI_PARITY_EN
  task automatic test_parity();
    logic [FRAME_W-1:0] d;
    d = 64'h0123_4567_89AB_CDEE;
    model_good(d);
    send_bits({63'd0, d, ^d}, EXP);
    wait_done(errs);
    obs = {errs, frame_valid, overrun, frame_data};
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL parity_good: got %h expected %h", obs, e); end
    model_bad();
    send_bits({63'd0, ~d, ~^d}, EXP);
    wait_done(errs);
    obs = {errs, frame_valid, overrun, frame_data};
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL parity_bad: got %h expected %h", obs, e); end
    do_ack();
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_length();
    test_back_to_back_overrun();
    test_ncs_abort();
    test_reset_mid_frame();
`ifdef DD_SPI_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
